// File: rtl/mips_exec_decode.sv
// mips_exec_decode: single-cycle MIPS main decode, ALU-control decode and
// 32-bit ALU, followed by one output register stage (1 clk latency).
// Optional feature macro: OVERFLOW_TRAP_EN -- flags signed overflow on
// add/sub/addi and suppresses the register write for those results.
module mips_exec_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm,
    output logic        out_valid,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic        jump,
    output logic        branch,
    output logic        reg_write,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  alu_op,
    output logic [3:0]  alu_ctl,
    output logic        ovf
);
    typedef struct packed {
        logic       jump;
        logic       branch;
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_op;
        logic [3:0] alu_ctl;
        logic       ovf;
    } ctl_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_ORI = 6'b001101,
                           OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] FN_JR = 6'b001000, FN_ADD = 6'b100000, FN_ADDU = 6'b100001,
                           FN_SUB = 6'b100010, FN_SUBU = 6'b100011, FN_AND = 6'b100100,
                           FN_OR = 6'b100101, FN_XOR = 6'b100110, FN_NOR = 6'b100111,
                           FN_SLT = 6'b101010, FN_SLL = 6'b000000, FN_SRL = 6'b000010,
                           FN_SRA = 6'b000011;
    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010,
                           ALU_SLL = 4'b0011, ALU_SRL = 4'b0100, ALU_SRA = 4'b0101,
                           ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100,
                           ALU_XOR = 4'b1101;

    ctl_t        dec_c, ctl_fin, ctl_d, ctl_q;
    logic [31:0] op_b, sum, diff, alu_res, alu_out_d, alu_out_q;
    logic        ovf_c, zero_d, zero_q, out_valid_d, out_valid_q;

    // Main control decode followed by ALU-control decode
    always_comb begin
        dec_c = '0;
        case (opcode)
            OP_R: begin
                dec_c.reg_dst   = 2'b01;
                dec_c.reg_write = (funct != FN_JR);
                dec_c.jump      = (funct == FN_JR);
                dec_c.alu_op    = 2'b10;
            end
            OP_LW: begin
                dec_c.alu_src    = 1'b1;
                dec_c.mem_read   = 1'b1;
                dec_c.mem_to_reg = 2'b01;
                dec_c.reg_write  = 1'b1;
            end
            OP_SW: begin
                dec_c.alu_src   = 1'b1;
                dec_c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_c.branch = 1'b1;
                dec_c.alu_op = 2'b01;
            end
            OP_ADDI: begin
                dec_c.alu_src   = 1'b1;
                dec_c.reg_write = 1'b1;
            end
            OP_ORI: begin
                dec_c.alu_src   = 1'b1;
                dec_c.reg_write = 1'b1;
                dec_c.alu_op    = 2'b11;
            end
            OP_J:   dec_c.jump = 1'b1;
            OP_JAL: begin
                dec_c.jump       = 1'b1;
                dec_c.reg_dst    = 2'b10;
                dec_c.mem_to_reg = 2'b10;
                dec_c.reg_write  = 1'b1;
            end
            default: ;
        endcase
        case (dec_c.alu_op)
            2'b01:   dec_c.alu_ctl = ALU_SUB;
            2'b11:   dec_c.alu_ctl = ALU_OR;
            2'b10: begin
                case (funct)
                    FN_SUB, FN_SUBU: dec_c.alu_ctl = ALU_SUB;
                    FN_AND:          dec_c.alu_ctl = ALU_AND;
                    FN_OR:           dec_c.alu_ctl = ALU_OR;
                    FN_XOR:          dec_c.alu_ctl = ALU_XOR;
                    FN_NOR:          dec_c.alu_ctl = ALU_NOR;
                    FN_SLT:          dec_c.alu_ctl = ALU_SLT;
                    FN_SLL:          dec_c.alu_ctl = ALU_SLL;
                    FN_SRL:          dec_c.alu_ctl = ALU_SRL;
                    FN_SRA:          dec_c.alu_ctl = ALU_SRA;
                    default:         dec_c.alu_ctl = ALU_ADD;  // add/addu and unknown funct
                endcase
            end
            default: dec_c.alu_ctl = ALU_ADD;
        endcase
    end

    // ori takes a zero-extended immediate; every other immediate is sign-extended
    assign op_b = !dec_c.alu_src   ? rt_data :
                  (opcode == OP_ORI) ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    assign sum  = rs_data + op_b;
    assign diff = rs_data - op_b;

    // 32-bit ALU; unassigned control codes produce zero
    always_comb begin
        alu_res = '0;
        case (dec_c.alu_ctl)
            ALU_AND: alu_res = rs_data & op_b;
            ALU_OR:  alu_res = rs_data | op_b;
            ALU_ADD: alu_res = sum;
            ALU_SUB: alu_res = diff;
            ALU_XOR: alu_res = rs_data ^ op_b;
            ALU_NOR: alu_res = ~(rs_data | op_b);
            ALU_SLT: alu_res = {31'b0, $signed(rs_data) < $signed(op_b)};
            ALU_SLL: alu_res = op_b << shamt;
            ALU_SRL: alu_res = op_b >> shamt;
            ALU_SRA: alu_res = $signed(op_b) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Signed-overflow trap: only the trapping add/sub/addi forms participate
    always_comb begin
        ovf_c = 1'b0;
`ifdef OVERFLOW_TRAP_EN
        if ((opcode == OP_R && funct == FN_ADD) || opcode == OP_ADDI)
            ovf_c = (rs_data[31] == op_b[31]) && (sum[31] != rs_data[31]);
        else if (opcode == OP_R && funct == FN_SUB)
            ovf_c = (rs_data[31] != op_b[31]) && (diff[31] != rs_data[31]);
`endif
        ctl_fin     = dec_c;
        ctl_fin.ovf = ovf_c;
        if (ovf_c)
            ctl_fin.reg_write = 1'b0;
    end

    // Output stage next-state: idle cycles clear controls but keep the last result
    always_comb begin
        out_valid_d = in_valid;
        alu_out_d   = alu_out_q;
        zero_d      = zero_q;
        ctl_d       = '0;
        if (in_valid) begin
            alu_out_d = alu_res;
            zero_d    = (alu_res == 32'd0);
            ctl_d     = ctl_fin;
        end
    end

    // Output register stage; reset drops any in-flight result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            zero_q      <= 1'b0;
            ctl_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            zero_q      <= zero_d;
            ctl_q       <= ctl_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_out    = alu_out_q;
    assign zero       = zero_q;
    assign jump       = ctl_q.jump;
    assign branch     = ctl_q.branch;
    assign reg_write  = ctl_q.reg_write;
    assign alu_src    = ctl_q.alu_src;
    assign mem_read   = ctl_q.mem_read;
    assign mem_write  = ctl_q.mem_write;
    assign reg_dst    = ctl_q.reg_dst;
    assign mem_to_reg = ctl_q.mem_to_reg;
    assign alu_op     = ctl_q.alu_op;
    assign alu_ctl    = ctl_q.alu_ctl;
    assign ovf        = ctl_q.ovf;
endmodule

// File: tb/tb_mips_exec_decode.sv
// Testbench for mips_exec_decode: directed vectors plus randomized traffic
// checked against an instruction-level reference model.
module tb_mips_exec_decode;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [5:0]  opcode = '0, funct = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic [15:0] imm = '0;
    logic        out_valid, zero, jump, branch, reg_write, alu_src, mem_read, mem_write, ovf;
    logic [31:0] alu_out;
    logic [1:0]  reg_dst, mem_to_reg, alu_op;
    logic [3:0]  alu_ctl;

    typedef struct packed {
        logic        out_valid;
        logic [31:0] alu_out;
        logic        zero;
        logic        jump;
        logic        branch;
        logic        reg_write;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  reg_dst;
        logic [1:0]  mem_to_reg;
        logic [1:0]  alu_op;
        logic [3:0]  alu_ctl;
        logic        ovf;
    } obs_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] im;
        logic [31:0] want;
    } vec_t;

    obs_t act, expv, prev;
    int   n_tests = 0;
    int   n_fail  = 0;

    assign act = {out_valid, alu_out, zero, jump, branch, reg_write, alu_src, mem_read,
                  mem_write, reg_dst, mem_to_reg, alu_op, alu_ctl, ovf};

    mips_exec_decode dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode), .funct(funct),
        .shamt(shamt), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .out_valid(out_valid), .alu_out(alu_out), .zero(zero), .jump(jump),
        .branch(branch), .reg_write(reg_write), .alu_src(alu_src), .mem_read(mem_read),
        .mem_write(mem_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .alu_ctl(alu_ctl), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Instruction-level reference: what each MIPS instruction should produce
    function automatic obs_t model(logic v, logic [5:0] op, logic [5:0] fn, logic [4:0] sh,
                                   logic [31:0] a, logic [31:0] bt, logic [15:0] im, obs_t p);
        obs_t        e;
        logic [31:0] sx, r;
        longint      wide;
        logic        trap_form;
        e = '0;
        if (!v) begin
            e.alu_out = p.alu_out;
            e.zero    = p.zero;
            return e;
        end
        sx = {{16{im[15]}}, im};
        e.out_valid = 1'b1;
        e.alu_ctl   = 4'd2;
        e.alu_out   = a + bt;
        wide        = 0;
        trap_form   = 1'b0;
        case (op)
            6'h00: begin
                e.reg_dst = 2'd1; e.alu_op = 2'd2;
                e.jump = (fn == 6'h08); e.reg_write = (fn != 6'h08);
                case (fn)
                    6'h20: begin trap_form = 1'b1;
                                 wide = longint'($signed(a)) + longint'($signed(bt)); end
                    6'h22: begin trap_form = 1'b1; e.alu_ctl = 4'd6; e.alu_out = a - bt;
                                 wide = longint'($signed(a)) - longint'($signed(bt)); end
                    6'h23: begin e.alu_ctl = 4'd6;  e.alu_out = a - bt; end
                    6'h24: begin e.alu_ctl = 4'd0;  e.alu_out = a & bt; end
                    6'h25: begin e.alu_ctl = 4'd1;  e.alu_out = a | bt; end
                    6'h26: begin e.alu_ctl = 4'd13; e.alu_out = a ^ bt; end
                    6'h27: begin e.alu_ctl = 4'd12; e.alu_out = ~(a | bt); end
                    6'h2A: begin e.alu_ctl = 4'd7;
                                 e.alu_out = ($signed(a) < $signed(bt)) ? 32'd1 : 32'd0; end
                    6'h00: begin e.alu_ctl = 4'd3;  e.alu_out = bt << sh; end
                    6'h02: begin e.alu_ctl = 4'd4;  e.alu_out = bt >> sh; end
                    6'h03: begin
                        e.alu_ctl = 4'd5;
                        r = bt;
                        for (int i = 0; i < 32; i++) if (i < sh) r = {r[31], r[31:1]};
                        e.alu_out = r;
                    end
                    default: ;
                endcase
            end
            6'h23: begin e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 2'd1;
                         e.reg_write = 1; e.alu_out = a + sx; end
            6'h2B: begin e.alu_src = 1; e.mem_write = 1; e.alu_out = a + sx; end
            6'h04: begin e.branch = 1; e.alu_op = 2'd1; e.alu_ctl = 4'd6; e.alu_out = a - bt; end
            6'h08: begin e.alu_src = 1; e.reg_write = 1; e.alu_out = a + sx; trap_form = 1'b1;
                         wide = longint'($signed(a)) + longint'($signed(sx)); end
            6'h0D: begin e.alu_src = 1; e.reg_write = 1; e.alu_op = 2'd3; e.alu_ctl = 4'd1;
                         e.alu_out = a | {16'h0, im}; end
            6'h02: e.jump = 1;
            6'h03: begin e.jump = 1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; e.reg_write = 1; end
            default: ;
        endcase
`ifdef OVERFLOW_TRAP_EN
        if (trap_form && (wide > 64'sd2147483647 || wide < -64'sd2147483648)) begin
            e.ovf = 1'b1;
            e.reg_write = 1'b0;
        end
`endif
        e.zero = (e.alu_out == 32'd0);
        return e;
    endfunction

    // Present one input set, clock it through, and update the expected outputs
    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] im);
        in_valid = v; opcode = op; funct = fn; shamt = sh;
        rs_data = a; rt_data = b; imm = im;
        @(posedge clk);
        #1;
        expv = model(v, op, fn, sh, a, b, im, prev);
        prev = expv;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", act);
        end
        prev  = '0;
        reset = 1'b0;
    endtask

    task automatic test_spec_vectors;
        vec_t vecs[10];
        vecs[0] = '{6'h00, 6'h20, 5'd0, 32'd5,          32'd7,          16'h0000, 32'd12};
        vecs[1] = '{6'h00, 6'h22, 5'd0, 32'h1234,       32'h1234,       16'h0000, 32'd0};
        vecs[2] = '{6'h04, 6'h00, 5'd0, 32'h1234,       32'h1234,       16'h0000, 32'd0};
        vecs[3] = '{6'h23, 6'h00, 5'd0, 32'h100,        32'h0,          16'hFFFC, 32'hFC};
        vecs[4] = '{6'h00, 6'h03, 5'd4, 32'h0,          32'h80000000,   16'h0000, 32'hF8000000};
        vecs[5] = '{6'h00, 6'h2A, 5'd0, 32'hFFFFFFFF,   32'd1,          16'h0000, 32'd1};
        vecs[6] = '{6'h03, 6'h00, 5'd0, 32'h0,          32'h0,          16'h0000, 32'd0};
        vecs[7] = '{6'h00, 6'h20, 5'd0, 32'h7FFFFFFF,   32'd1,          16'h0000, 32'h80000000};
        vecs[8] = '{6'h0D, 6'h00, 5'd0, 32'hF0000000,   32'h0,          16'h8001, 32'hF0008001};
        vecs[9] = '{6'h08, 6'h00, 5'd0, 32'd10,         32'h0,          16'hFFFF, 32'd9};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].fn, vecs[i].sh, vecs[i].a, vecs[i].b, vecs[i].im);
            n_tests++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL vec%0d_model: got %h want %h", i, act, expv);
            end
            n_tests++;
            if (alu_out !== vecs[i].want) begin
                n_fail++;
                $display("FAIL vec%0d_alu_out: got %h want %h", i, alu_out, vecs[i].want);
            end
            if (i == 6) begin
                n_tests++;
                if ({jump, reg_dst, mem_to_reg, reg_write} !== {1'b1, 2'b10, 2'b10, 1'b1}) begin
                    n_fail++;
                    $display("FAIL jal_ctl: got %b%b%b%b want 1 10 10 1",
                             jump, reg_dst, mem_to_reg, reg_write);
                end
            end
            if (i == 7) begin
                n_tests++;
`ifdef OVERFLOW_TRAP_EN
                if ({ovf, reg_write} !== 2'b10) begin
`else
                if ({ovf, reg_write} !== 2'b01) begin
`endif
                    n_fail++;
                    $display("FAIL add_ovf: got ovf=%b reg_write=%b", ovf, reg_write);
                end
            end
        end
    endtask

    task automatic test_invalid_hold;
        drive(1'b1, 6'h00, 6'h25, 5'd0, 32'h00F0, 32'h0F00, 16'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 6'h23, 6'h20, 5'd3, $urandom, $urandom, 16'($urandom));
            n_tests++;
            if (act !== expv || alu_out !== 32'h0FF0) begin
                n_fail++;
                $display("FAIL invalid_hold%0d: got %h want %h", i, act, expv);
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 6'h03, 6'h00, 5'd0, 32'd3, 32'd4, 16'h0);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 0", act);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got %h want 0", act);
        end
        #3 reset = 1'b0;
        prev = '0;
        drive(1'b1, 6'h00, 6'h27, 5'd0, 32'h0, 32'h0, 16'h0);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL reset_recover: got %h want %h", act, expv);
        end
    endtask

    task automatic test_random;
        logic [5:0]  ops[9];
        logic [5:0]  fns[15];
        logic [31:0] edges[4];
        logic [5:0]  op, fn;
        logic [31:0] a, b;
        ops   = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0D, 6'h02, 6'h03};
        fns   = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                  6'h00, 6'h02, 6'h03, 6'h08, 6'h3F, 6'h11};
        edges = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 9) == 9) ? 6'($urandom) : fns[$urandom_range(0, 14)];
            a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            drive($urandom_range(0, 6) != 0, op, fn, 5'($urandom), a, b, 16'($urandom));
            n_tests++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL random%0d op=%h fn=%h: got %h want %h", i, op, fn, act, expv);
            end
        end
    endtask

    initial begin
        prev = '0;
        expv = '0;
        test_reset();
        test_spec_vectors();
        test_invalid_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
